// File: rtl/uparc_mem_access_pkg.sv
// Shared definitions for the uparc memory-access stage: LSU op encodings,
// stage FSM states and the alignment rule.
package uparc_mem_access_pkg;

  localparam logic [1:0] UPARC_LSU_IDLE  = 2'd0;
  localparam logic [1:0] UPARC_LSU_BYTE  = 2'd1;
  localparam logic [1:0] UPARC_LSU_HWORD = 2'd2;
  localparam logic [1:0] UPARC_LSU_WORD  = 2'd3;

  typedef enum logic {
    UPARC_MEMST_IDLE = 1'b0,
    UPARC_MEMST_BUSY = 1'b1
  } memst_e;

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] a_lo);
    return ((op == UPARC_LSU_HWORD) && a_lo[0]) ||
           ((op == UPARC_LSU_WORD) && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/uparc_mem_access_lsu_align.sv
// Byte-lane helper: store byte enables / lane replication and load byte/half
// extraction with sign or zero extension. Purely combinational.
module uparc_mem_access_lsu_align
  import uparc_mem_access_pkg::*;
(
  input  logic [1:0]  i_st_op,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_op,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_ext,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    case (i_st_op)
      UPARC_LSU_BYTE: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      UPARC_LSU_HWORD: begin
        o_st_be    = 4'b0011 << {i_st_addr_lo[1], 1'b0};
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = i_ld_rdata[7:0];
    case (i_ld_addr_lo)
      2'd1:    ld_byte = i_ld_rdata[15:8];
      2'd2:    ld_byte = i_ld_rdata[23:16];
      2'd3:    ld_byte = i_ld_rdata[31:24];
      default: ld_byte = i_ld_rdata[7:0];
    endcase
    ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

    o_ld_data = i_ld_rdata;
    case (i_ld_op)
      UPARC_LSU_BYTE:  o_ld_data = {{24{i_ld_ext & ld_byte[7]}}, ld_byte};
      UPARC_LSU_HWORD: o_ld_data = {{16{i_ld_ext & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/uparc_mem_access.sv
// uparc memory-access stage: single-outstanding req/ack bus master between
// execute and writeback, with misalignment detection and load alignment.
module uparc_mem_access
  import uparc_mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int REGNO_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_exec_stall,
  input  logic                   i_fetch_stall,
  output logic                   o_mem_stall,
  input  logic [REGNO_WIDTH-1:0] i_rd_no,
  input  logic [DATA_WIDTH-1:0]  i_alu_result,
  input  logic [1:0]             i_lsu_op,
  input  logic                   i_lsu_lns,
  input  logic                   i_lsu_ext,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  output logic                   o_addr_error,
  output logic [ADDR_WIDTH-1:0]  o_bad_addr,
  output logic                   o_bus_req,
  output logic                   o_bus_wr,
  output logic [ADDR_WIDTH-1:0]  o_bus_addr,
  output logic [3:0]             o_bus_be,
  output logic [DATA_WIDTH-1:0]  o_bus_wdata,
  input  logic [DATA_WIDTH-1:0]  i_bus_rdata,
  input  logic                   i_bus_ack,
  output logic [REGNO_WIDTH-1:0] o_rd_no,
  output logic [DATA_WIDTH-1:0]  o_rd_val,
  output memst_e                 o_dbg_state
);

  memst_e                 state_q, state_d;
  logic [REGNO_WIDTH-1:0] cap_rd_q, cap_rd_d;
  logic [1:0]             cap_alo_q, cap_alo_d;
  logic [1:0]             cap_op_q, cap_op_d;
  logic                   cap_ext_q, cap_ext_d;
  logic                   bus_req_q, bus_req_d;
  logic                   bus_wr_q, bus_wr_d;
  logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
  logic [3:0]             bus_be_q, bus_be_d;
  logic [DATA_WIDTH-1:0]  bus_wdata_q, bus_wdata_d;
  logic [REGNO_WIDTH-1:0] rd_no_q, rd_no_d;
  logic [DATA_WIDTH-1:0]  rd_val_q, rd_val_d;
  logic                   addr_err_q, addr_err_d;
  logic [ADDR_WIDTH-1:0]  bad_addr_q, bad_addr_d;

  logic                   ext_stall;
  logic [3:0]             st_be;
  logic [DATA_WIDTH-1:0]  st_wdata;
  logic [DATA_WIDTH-1:0]  ld_data;

  assign ext_stall = i_exec_stall | i_fetch_stall;

  // Store lanes come from the live execute inputs; load extraction uses the
  // attributes captured when the transfer was launched.
  uparc_mem_access_lsu_align u_align (
    .i_st_op      (i_lsu_op),
    .i_st_addr_lo (i_alu_result[1:0]),
    .i_st_data    (i_mem_data),
    .o_st_be      (st_be),
    .o_st_wdata   (st_wdata),
    .i_ld_op      (cap_op_q),
    .i_ld_addr_lo (cap_alo_q),
    .i_ld_ext     (cap_ext_q),
    .i_ld_rdata   (i_bus_rdata),
    .o_ld_data    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cap_rd_d    = cap_rd_q;
    cap_alo_d   = cap_alo_q;
    cap_op_d    = cap_op_q;
    cap_ext_d   = cap_ext_q;
    bus_req_d   = bus_req_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rd_no_d     = rd_no_q;
    rd_val_d    = rd_val_q;
    addr_err_d  = 1'b0;
    bad_addr_d  = bad_addr_q;

    case (state_q)
      UPARC_MEMST_IDLE: begin
        if (!ext_stall) begin
          if (i_lsu_op == UPARC_LSU_IDLE) begin
            rd_no_d  = i_rd_no;
            rd_val_d = i_alu_result;
          end else if (is_misaligned(i_lsu_op, i_alu_result[1:0])) begin
            addr_err_d = 1'b1;
            bad_addr_d = i_alu_result[ADDR_WIDTH-1:0];
            rd_no_d    = '0;
          end else begin
            cap_rd_d    = i_rd_no;
            cap_alo_d   = i_alu_result[1:0];
            cap_op_d    = i_lsu_op;
            cap_ext_d   = i_lsu_ext;
            bus_req_d   = 1'b1;
            bus_wr_d    = ~i_lsu_lns;
            bus_addr_d  = {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
            rd_no_d     = '0;
            state_d     = UPARC_MEMST_BUSY;
          end
        end
      end
      UPARC_MEMST_BUSY: begin
        // Completion retires regardless of ext_stall; upstream is already held.
        if (i_bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = UPARC_MEMST_IDLE;
          if (!bus_wr_q) begin
            rd_no_d  = cap_rd_q;
            rd_val_d = ld_data;
          end else begin
            rd_no_d = '0;
          end
        end
      end
      default: state_d = UPARC_MEMST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UPARC_MEMST_IDLE;
      cap_rd_q    <= '0;
      cap_alo_q   <= '0;
      cap_op_q    <= UPARC_LSU_IDLE;
      cap_ext_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rd_no_q     <= '0;
      rd_val_q    <= '0;
      addr_err_q  <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cap_rd_q    <= cap_rd_d;
      cap_alo_q   <= cap_alo_d;
      cap_op_q    <= cap_op_d;
      cap_ext_q   <= cap_ext_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rd_no_q     <= rd_no_d;
      rd_val_q    <= rd_val_d;
      addr_err_q  <= addr_err_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign o_mem_stall  = (state_q == UPARC_MEMST_BUSY);
  assign o_addr_error = addr_err_q;
  assign o_bad_addr   = bad_addr_q;
  assign o_bus_req    = bus_req_q;
  assign o_bus_wr     = bus_wr_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_be     = bus_be_q;
  assign o_bus_wdata  = bus_wdata_q;
  assign o_rd_no      = rd_no_q;
  assign o_rd_val     = rd_val_q;
  assign o_dbg_state  = state_q;

endmodule
